// File: rtl/booth_mac_pkg.sv
// rtl/booth_mac_pkg.sv - shared widths, FSM state type and accumulator limits for the Booth MAC
package booth_mac_pkg;

    localparam int ACC_W_DEF  = 40;
    localparam int PROD_W_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_mac_add40.sv
// rtl/booth_mac_add40.sv - sign-extending accumulate adder with overflow detect; BOOTH_MAC_SATURATE_EN selects clamping
module booth_mac_add40
    import booth_mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    assign ext   = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign raw   = acc_i + ext;
    assign ovf_o = (acc_i[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);

`ifdef BOOTH_MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow needs equal operand signs, so the accumulator sign gives the clamp direction.
    assign sum_o = ovf_o ? (acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/booth_mac_accumulator.sv
// rtl/booth_mac_accumulator.sv - dot-product accumulator over Booth products; build option BOOTH_MAC_SATURATE_EN
module booth_mac_accumulator
    import booth_mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    booth_mac_add40 #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (in_product),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    assign in_ready     = (state_q == ACCUM) && !clr;
    assign accept       = in_valid && in_ready;
    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign out_valid    = (state_q == DRAIN);
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_sum_d   = add_sum;
                            out_count_d = cnt_inc;
                            out_ovf_d   = ovf_q | add_ovf;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_d       = 1'b0;
                            state_d     = DRAIN;
                        end else begin
                            acc_d = add_sum;
                            cnt_d = cnt_inc;
                            ovf_d = ovf_q | add_ovf;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: doc/booth_mac_accumulator.md
# booth_mac_accumulator

Downstream consumer of the 16x16 combinational Booth multiplier. Accepts one signed 32-bit product per beat over a valid/ready handshake and accumulates products into a 40-bit signed dot-product sum. On the beat flagged last, it presents the finished sum, term count and overflow flag on an output handshake. Sits between the multiplier's `z` output and the result-consuming logic of the datapath.

## Interface
Parameters:
- `ACC_W`, 40, accumulator and result width; must be ≥ `PROD_W` + 8.
- `PROD_W`, 32, product width, matching the multiplier output.
- `CNT_W`, 8, term-counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous discard of the current partial sum.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_product` in `PROD_W`: signed product, multiplier `z`.
- `in_last` in 1: beat is the final term of the dot product.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out `ACC_W`: signed dot-product result.
- `out_count` out `CNT_W`: number of terms accumulated; saturates at 255.
- `out_overflow` out 1: sticky signed overflow seen during this dot product.

## Operation
- FSM states:
  - ACCUM (reset state): accepts beats.
  - DRAIN: holds the result.
- `in_ready` = (state==ACCUM) && !`clr`.
- A beat is accepted when `in_valid` && `in_ready`.
- On an accepted beat:
  - Sign-extend `in_product` to `ACC_W`.
  - next = acc + ext.
  - Overflow occurs when the operand signs are equal and the sign of next differs.
  - Overflow ORs into sticky `ovf`.
  - `cnt` increments and saturates at 2^CNT_W−1.
- Accepted beat with `in_last`=0: acc←next, stay in ACCUM.
- Accepted beat with `in_last`=1:
  - `out_sum`←next, `out_count`←`cnt`+1 (saturating), `out_overflow`←`ovf`|overflow.
  - acc, `cnt`, `ovf` ← 0; go to DRAIN.
- DRAIN: `out_valid`=1 and all outputs are held stable. When `out_ready`=1, go to ACCUM and deassert `out_valid` next cycle.
- `clr`=1 (any state):
  - acc, `cnt`, `ovf` ← 0; state←ACCUM; `out_valid`←0.
  - A beat presented in the same cycle is not accepted.
  - `clr` has priority over the handshake.
- `reset` is identical to `clr`, and additionally zeroes `out_sum`, `out_count` and `out_overflow`.
- Reset values: `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0, `in_ready`=1 (when `clr`=0).

## Timing
- Latency: a last beat accepted at edge N gives `out_valid`=1 from cycle N+1.
- `in_ready` drops in the same cycle.
- Throughput: one beat per cycle in ACCUM, including back-to-back beats after a DRAIN handoff.
- One bubble cycle on input per dot product: DRAIN lasts at least 1 cycle.
- `out_valid` never drops without `out_ready`, except on `clr`/`reset`.
- Reset or `clr` mid-dot-product: partial state is lost in the next cycle, with no output produced.

## Configuration
- `BOOTH_MAC_SATURATE_EN` defined: on overflow, next is clamped to 0x7F_FFFF_FFFF (positive overflow) or 0x80_0000_0000 (negative overflow). Once saturated, the clamp is re-applied per beat.
- `BOOTH_MAC_SATURATE_EN` undefined: next wraps modulo 2^ACC_W.
- `out_overflow` is reported identically in both builds.

## Structure
- Shared package `booth_mac_pkg`:
  - `ACC_W`/`PROD_W`/`CNT_W` defaults.
  - State enum {ACCUM, DRAIN}.
  - `ACC_MAX`/`ACC_MIN` constants.
- Sub-module `booth_mac_add40`: combinational sign-extend, add, overflow detect and optional saturation. It holds the `BOOTH_MAC_SATURATE_EN` conditional.
- FSM, counters and output registers live in the top module.

## Test plan
- Reset asserted 2 cycles → `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0, `in_ready`=1.
- Beats 6, −3, 10 with last on the third, `out_ready`=1 → one cycle later `out_sum`=13, `out_count`=3, `out_overflow`=0; `out_valid` high 1 cycle.
- Single beat 0xFFFF_FFFF with last, `out_ready` held 0 for 3 cycles → `out_sum`=0xFF_FFFF_FFFF and `out_count`=1 held stable; `in_ready`=0 throughout; after `out_ready`, `in_ready`=1 next cycle.
- Beats 5, 7, then `clr` together with `in_valid` for beat 9, then 4 with last → 9 not accepted; `out_sum`=4, `out_count`=1.
- 300 beats of 0x7FFF_FFFF, last on the 300th:
  - With SAT: `out_sum`=0x7F_FFFF_FFFF.
  - Without SAT: `out_sum`=0x95_FFFF_FED4.
  - Both builds: `out_overflow`=1, `out_count`=255.
- `reset` asserted while in DRAIN with `out_ready`=0 → next cycle `out_valid`=0, `out_sum`=0, state ACCUM.
